// File: rtl/dsp_mac_pkg.sv
// Shared types and constants for the parametrised DSP MAC slice.
// Holds the X/Z operand selects, OPMODE bit positions and the pipeline latency helper.
package dsp_mac_pkg;

  typedef enum logic [1:0] {
    X_ZERO = 2'd0,
    X_M    = 2'd1,
    X_P    = 2'd2,
    X_AB   = 2'd3
  } x_sel_e;

  typedef enum logic [1:0] {
    Z_ZERO = 2'd0,
    Z_PCIN = 2'd1,
    Z_P    = 2'd2,
    Z_C    = 2'd3
  } z_sel_e;

  localparam int OP_X_LSB    = 0;
  localparam int OP_Z_LSB    = 2;
  localparam int OP_PRE_EN   = 4;
  localparam int OP_PRE_SUB  = 5;
  localparam int OP_POST_SUB = 6;
  localparam int OP_RSVD     = 7;
  // Only the functional OPMODE bits travel down the pipe; the reserved bit is dropped.
  localparam int OP_W        = 7;

  function automatic int unsigned mac_latency(input bit mreg);
    return mreg ? 3 : 2;
  endfunction

endpackage

// File: rtl/dsp_preadd_mult.sv
// Input registers, (D +/- B) pre-adder and A*pre multiplier with optional M stage.
// Side operands (C, PCIN, OPMODE, CARRYIN, {A,B}) are delayed to line up with M.
module dsp_preadd_mult
  import dsp_mac_pkg::*;
#(
  parameter int AW   = 18,
  parameter int BW   = 18,
  parameter int CW   = 48,
  parameter int PW   = 48,
  parameter int MREG = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ce,
  input  logic            sclr,
  input  logic            in_valid,
  input  logic [AW-1:0]   a,
  input  logic [BW-1:0]   b,
  input  logic [BW-1:0]   d,
  input  logic [CW-1:0]   c,
  input  logic [PW-1:0]   pcin,
  input  logic [OP_W-1:0] opmode,
  input  logic            carryin,
  output logic [PW-1:0]   m,
  output logic [PW-1:0]   ab,
  output logic [PW-1:0]   c_ext,
  output logic [PW-1:0]   pcin_s,
  output logic [OP_W-1:0] opmode_s,
  output logic            carryin_s,
  output logic            valid_s
);

  logic [AW-1:0]    a_r;
  logic [BW-1:0]    b_r, d_r;
  logic [CW-1:0]    c_r;
  logic [PW-1:0]    pcin_r;
  logic [OP_W-1:0]  op_r;
  logic             cin_r, v1;
  logic [BW-1:0]    pre;
  logic [AW+BW-1:0] mult;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r <= '0; b_r <= '0; d_r <= '0; c_r <= '0;
      pcin_r <= '0; op_r <= '0; cin_r <= 1'b0; v1 <= 1'b0;
    end else if (sclr) begin
      a_r <= '0; b_r <= '0; d_r <= '0; c_r <= '0;
      pcin_r <= '0; op_r <= '0; cin_r <= 1'b0; v1 <= 1'b0;
    end else if (ce) begin
      v1 <= in_valid;
      if (in_valid) begin
        a_r <= a; b_r <= b; d_r <= d; c_r <= c;
        pcin_r <= pcin; op_r <= opmode; cin_r <= carryin;
      end
    end
  end

  assign pre  = op_r[OP_PRE_EN] ? (op_r[OP_PRE_SUB] ? d_r - b_r : d_r + b_r) : b_r;
  assign mult = (AW+BW)'(a_r) * (AW+BW)'(pre);

  if (MREG != 0) begin : g_mreg
    logic [PW-1:0]   m_r, ab_r, c_r2, pcin_r2;
    logic [OP_W-1:0] op_r2;
    logic            cin_r2, v2;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        m_r <= '0; ab_r <= '0; c_r2 <= '0; pcin_r2 <= '0;
        op_r2 <= '0; cin_r2 <= 1'b0; v2 <= 1'b0;
      end else if (sclr) begin
        m_r <= '0; ab_r <= '0; c_r2 <= '0; pcin_r2 <= '0;
        op_r2 <= '0; cin_r2 <= 1'b0; v2 <= 1'b0;
      end else if (ce) begin
        v2 <= v1;
        if (v1) begin
          m_r <= PW'(mult); ab_r <= PW'({a_r, b_r}); c_r2 <= PW'(c_r);
          pcin_r2 <= pcin_r; op_r2 <= op_r; cin_r2 <= cin_r;
        end
      end
    end

    assign m = m_r;  assign ab = ab_r;  assign c_ext = c_r2;  assign pcin_s = pcin_r2;
    assign opmode_s = op_r2;  assign carryin_s = cin_r2;  assign valid_s = v2;
  end else begin : g_no_mreg
    assign m = PW'(mult);  assign ab = PW'({a_r, b_r});  assign c_ext = PW'(c_r);
    assign pcin_s = pcin_r;  assign opmode_s = op_r;  assign carryin_s = cin_r;
    assign valid_s = v1;
  end

endmodule

// File: rtl/dsp_mac_pipe.sv
// Parametrised DSP MAC lane: pre-adder/multiplier front end, X/Z post-adder with
// carry in/out, optional saturation, P accumulator register and PCIN/PCOUT cascade.
module dsp_mac_pipe
  import dsp_mac_pkg::*;
#(
  parameter int AW     = 18,
  parameter int BW     = 18,
  parameter int CW     = 48,
  parameter int PW     = 48,
  parameter int MREG   = 1,
  parameter int SAT_EN = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ce,
  input  logic          sclr,
  input  logic          in_valid,
  input  logic [AW-1:0] a,
  input  logic [BW-1:0] b,
  input  logic [BW-1:0] d,
  input  logic [CW-1:0] c,
  input  logic [PW-1:0] pcin,
  input  logic [7:0]    opmode,
  input  logic          carryin,
  output logic [PW-1:0] p,
  output logic [PW-1:0] pcout,
  output logic          carryout,
  output logic          ovf,
  output logic          out_valid
);

  logic [PW-1:0]   m, ab, c_ext, pcin_s;
  logic [OP_W-1:0] op_s;
  logic            cin_s, valid_s;

  dsp_preadd_mult #(
    .AW(AW), .BW(BW), .CW(CW), .PW(PW), .MREG(MREG)
  ) u_front (
    .clk(clk), .rst_n(rst_n), .ce(ce), .sclr(sclr), .in_valid(in_valid),
    .a(a), .b(b), .d(d), .c(c), .pcin(pcin), .opmode(opmode[OP_W-1:0]),
    .carryin(carryin), .m(m), .ab(ab), .c_ext(c_ext), .pcin_s(pcin_s),
    .opmode_s(op_s), .carryin_s(cin_s), .valid_s(valid_s)
  );

  x_sel_e        x_sel;
  z_sel_e        z_sel;
  logic          post_sub;
  logic [PW-1:0] x_val, z_val, p_next;
  logic [PW:0]   sum;
  logic          ovf_next;

  assign x_sel    = x_sel_e'(op_s[OP_X_LSB +: 2]);
  assign z_sel    = z_sel_e'(op_s[OP_Z_LSB +: 2]);
  assign post_sub = op_s[OP_POST_SUB];

  // NOTE: every always_comb output gets a default first, so no path can leave it
  // unassigned and infer a latch.
  always_comb begin
    x_val = '0;
    z_val = '0;
    case (x_sel)
      X_M:     x_val = m;
      X_P:     x_val = p;
      X_AB:    x_val = ab;
      default: x_val = '0;
    endcase
    case (z_sel)
      Z_PCIN:  z_val = pcin_s;
      Z_P:     z_val = p;
      Z_C:     z_val = c_ext;
      default: z_val = '0;
    endcase
  end

  // Bit PW of the extended sum is the carry on add and the borrow on subtract.
  always_comb begin
    if (post_sub) sum = {1'b0, z_val} - ({1'b0, x_val} + (PW+1)'(cin_s));
    else          sum = {1'b0, z_val} + {1'b0, x_val} + (PW+1)'(cin_s);
    p_next   = sum[PW-1:0];
    ovf_next = 1'b0;
    if (SAT_EN != 0 && sum[PW]) begin
      p_next   = post_sub ? '0 : '1;
      ovf_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p <= '0; carryout <= 1'b0; ovf <= 1'b0; out_valid <= 1'b0;
    end else if (sclr) begin
      p <= '0; carryout <= 1'b0; ovf <= 1'b0; out_valid <= 1'b0;
    end else if (ce) begin
      out_valid <= valid_s;
      if (valid_s) begin
        p        <= p_next;
        carryout <= sum[PW];
        ovf      <= ovf_next;
      end
    end
  end

  assign pcout = p;

  a_rsvd_zero: assert property (@(posedge clk) disable iff (!rst_n)
    (ce && in_valid && !sclr) |-> !opmode[OP_RSVD]);
  a_ab_fits: assert property (@(posedge clk) disable iff (!rst_n)
    (ce && in_valid && !sclr && opmode[OP_X_LSB +: 2] == 2'd3) |-> (AW + BW <= PW));

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Directed bench for dsp_mac_pipe: wrap (SAT_EN=0), saturating and MREG=0 instances
// share one stimulus stream; vector table plus accumulate, stall, reset and clear sequences.
module tb_dsp_mac_pipe;
  import dsp_mac_pkg::*;

  localparam int LAT = mac_latency(1'b1);

  logic        clk = 1'b0;
  logic        rst_n, ce, sclr, in_valid, cin;
  logic [17:0] a, b, d;
  logic [47:0] c, pcin;
  logic [7:0]  op;

  logic [47:0] p0, pc0, p1, pc1, p2, pc2;
  logic        co0, ov0, vo0, co1, ov1, vo1, co2, ov2, vo2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dsp_mac_pipe #(.MREG(1), .SAT_EN(0)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .sclr(sclr), .in_valid(in_valid),
    .a(a), .b(b), .d(d), .c(c), .pcin(pcin), .opmode(op), .carryin(cin),
    .p(p0), .pcout(pc0), .carryout(co0), .ovf(ov0), .out_valid(vo0));

  dsp_mac_pipe #(.MREG(1), .SAT_EN(1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .ce(ce), .sclr(sclr), .in_valid(in_valid),
    .a(a), .b(b), .d(d), .c(c), .pcin(pcin), .opmode(op), .carryin(cin),
    .p(p1), .pcout(pc1), .carryout(co1), .ovf(ov1), .out_valid(vo1));

  dsp_mac_pipe #(.MREG(0), .SAT_EN(0)) dut_m0 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .sclr(sclr), .in_valid(in_valid),
    .a(a), .b(b), .d(d), .c(c), .pcin(pcin), .opmode(op), .carryin(cin),
    .p(p2), .pcout(pc2), .carryout(co2), .ovf(ov2), .out_valid(vo2));

  typedef struct {
    logic [17:0] a, b, d;
    logic [47:0] c, pcin;
    logic [7:0]  op;
    logic        cin;
    logic [47:0] p;
    logic        co;
    logic [47:0] p_sat;
    logic        ovf_sat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [17:0] va, vb, vd, input logic [47:0] vc, vpc,
                       input logic [7:0] vop, input logic vcin);
    a = va; b = vb; d = vd; c = vc; pcin = vpc; op = vop; cin = vcin;
    in_valid = 1'b1;
  endtask

  task automatic clear_pulse();
    sclr = 1'b1;
    step();
    sclr = 1'b0;
  endtask

  int          idx_in, idx_out;
  logic [47:0] exp_p;
  logic [2:0]  vpipe;

  initial begin
    vecs[0]  = '{18'd5, 18'd10, 18'd7, 48'd1, 48'd0, 8'h1D, 1'b0, 48'd86, 1'b0, 48'd86, 1'b0};
    vecs[1]  = '{18'd5, 18'd6, 18'd0, 48'd100, 48'd0, 8'h4D, 1'b1, 48'd69, 1'b0, 48'd69, 1'b0};
    vecs[2]  = '{18'd5, 18'd6, 18'd0, 48'd0, 48'd0, 8'h4D, 1'b1,
                 48'hFFFF_FFFF_FFE1, 1'b1, 48'd0, 1'b1};
    vecs[3]  = '{18'd1, 18'd1, 18'd0, 48'hFFFF_FFFF_FFFF, 48'd0, 8'h0D, 1'b0,
                 48'd0, 1'b1, 48'hFFFF_FFFF_FFFF, 1'b1};
    vecs[4]  = '{18'd3, 18'd5, 18'd20, 48'd10, 48'd0, 8'h3D, 1'b0, 48'd55, 1'b0, 48'd55, 1'b0};
    vecs[5]  = '{18'd2, 18'd1, 18'd0, 48'd0, 48'd0, 8'h3D, 1'b0,
                 48'd524286, 1'b0, 48'd524286, 1'b0};
    vecs[6]  = '{18'd1, 18'd2, 18'd0, 48'd0, 48'd1000, 8'h07, 1'b0,
                 48'd263146, 1'b0, 48'd263146, 1'b0};
    vecs[7]  = '{18'd0, 18'd0, 18'd0, 48'd0, 48'd7, 8'h04, 1'b1, 48'd8, 1'b0, 48'd8, 1'b0};
    vecs[8]  = '{18'h3FFFF, 18'h3FFFF, 18'd0, 48'd0, 48'd0, 8'h01, 1'b0,
                 48'd68718952449, 1'b0, 48'd68718952449, 1'b0};
    vecs[9]  = '{18'd0, 18'd0, 18'd0, 48'd50, 48'd0, 8'h4C, 1'b1, 48'd49, 1'b0, 48'd49, 1'b0};
    vecs[10] = '{18'd0, 18'd0, 18'd0, 48'd0, 48'd1, 8'h06, 1'b0, 48'd50, 1'b0, 48'd50, 1'b0};
    vecs[11] = '{18'd0, 18'd0, 18'd0, 48'd0, 48'd0, 8'h0A, 1'b0, 48'd100, 1'b0, 48'd100, 1'b0};

    rst_n = 1'b0; ce = 1'b1; sclr = 1'b0; in_valid = 1'b0; cin = 1'b0;
    a = '0; b = '0; d = '0; c = '0; pcin = '0; op = '0;
    step();
    check("reset_p", p0, 48'd0);
    check("reset_out_valid", vo0, 1'b0);
    check("reset_carryout", co0, 1'b0);
    check("reset_ovf_sat", ov1, 1'b0);
    check("reset_pcout", pc0, 48'd0);
    step();
    rst_n = 1'b1;
    step();

    // Vector table: one isolated sample each, checked at both latencies.
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].c, vecs[i].pcin, vecs[i].op, vecs[i].cin);
      step();
      in_valid = 1'b0;
      repeat (LAT - 2) step();
      check($sformatf("v%0d_m0_p", i), p2, vecs[i].p);
      check($sformatf("v%0d_m0_valid", i), vo2, 1'b1);
      check($sformatf("v%0d_early_valid", i), vo0, 1'b0);
      step();
      check($sformatf("v%0d_p", i), p0, vecs[i].p);
      check($sformatf("v%0d_pcout", i), pc0, vecs[i].p);
      check($sformatf("v%0d_carryout", i), co0, vecs[i].co);
      check($sformatf("v%0d_ovf_wrap", i), ov0, 1'b0);
      check($sformatf("v%0d_valid", i), vo0, 1'b1);
      check($sformatf("v%0d_sat_p", i), p1, vecs[i].p_sat);
      check($sformatf("v%0d_sat_carryout", i), co1, vecs[i].co);
      check($sformatf("v%0d_sat_ovf", i), ov1, vecs[i].ovf_sat);
      check($sformatf("v%0d_m0_pulse_end", i), vo2, 1'b0);
      step();
      check($sformatf("v%0d_pulse_end", i), vo0, 1'b0);
    end

    // Accumulate A*B with bubbles of growing length between samples.
    clear_pulse();
    for (int k = 1; k <= 4; k++) begin
      drive(18'd2, 18'd3, 18'd0, 48'd0, 48'd0, 8'h09, 1'b0);
      step();
      in_valid = 1'b0;
      repeat (LAT - 1) step();
      check($sformatf("acc%0d_p", k), p0, 48'(6 * k));
      check($sformatf("acc%0d_valid", k), vo0, 1'b1);
      repeat (k) step();
      check($sformatf("acc%0d_bubble_p", k), p0, 48'(6 * k));
      check($sformatf("acc%0d_bubble_valid", k), vo0, 1'b0);
    end

    // Back-to-back accumulate stream with a 5-cycle CE stall in the middle.
    clear_pulse();
    idx_in = 0; idx_out = 0; exp_p = '0; vpipe = '0;
    for (int t = 0; t < 16; t++) begin
      ce = !(t >= 4 && t < 9);
      if (idx_in < 6) drive(18'(idx_in + 1), 18'd1, 18'd0, 48'd0, 48'd0, 8'h09, 1'b0);
      else in_valid = 1'b0;
      if (ce) vpipe = {vpipe[1:0], in_valid};
      step();
      if (ce && in_valid) idx_in++;
      if (ce && vpipe[2]) begin
        idx_out++;
        exp_p = exp_p + 48'(idx_out);
      end
      check($sformatf("stall_t%0d_valid", t), vo0, vpipe[2]);
      check($sformatf("stall_t%0d_p", t), p0, exp_p);
    end
    ce = 1'b1;
    in_valid = 1'b0;
    check("stall_result_count", 64'(idx_out), 64'd6);
    check("stall_final_p", p0, 48'd21);

    // Asynchronous reset in the middle of an accumulation.
    clear_pulse();
    drive(18'd2, 18'd3, 18'd0, 48'd0, 48'd0, 8'h09, 1'b0);
    step();
    step();
    in_valid = 1'b0;
    step();
    check("rst_mid_before_p", p0, 48'd6);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_p", p0, 48'd0);
    check("rst_async_valid", vo0, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    drive(18'd2, 18'd3, 18'd0, 48'd0, 48'd0, 8'h09, 1'b0);
    step();
    in_valid = 1'b0;
    repeat (LAT - 1) step();
    check("post_rst_p", p0, 48'd6);
    check("post_rst_valid", vo0, 1'b1);

    // Synchronous clear with CE low still clears P and OUT_VALID.
    ce = 1'b0;
    clear_pulse();
    ce = 1'b1;
    check("sclr_ce0_p", p0, 48'd0);
    check("sclr_ce0_valid", vo0, 1'b0);

    // A sample presented together with SCLR is discarded.
    drive(18'd2, 18'd3, 18'd0, 48'd0, 48'd0, 8'h09, 1'b0);
    clear_pulse();
    in_valid = 1'b0;
    for (int s = 0; s < LAT; s++) begin
      step();
      check($sformatf("sclr_discard_valid%0d", s), vo0, 1'b0);
    end
    check("sclr_discard_p", p0, 48'd0);

    // Saturation flags are cleared by SCLR.
    drive(vecs[3].a, vecs[3].b, vecs[3].d, vecs[3].c, vecs[3].pcin, vecs[3].op, vecs[3].cin);
    step();
    in_valid = 1'b0;
    repeat (LAT - 1) step();
    check("sat_ovf_set", ov1, 1'b1);
    clear_pulse();
    check("sclr_sat_ovf", ov1, 1'b0);
    check("sclr_sat_carry", co1, 1'b0);
    check("sclr_sat_p", p1, 48'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
